// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples MDC in the fabric clock, decodes
// read/write frames and serves a small register set over a tri-stated MDIO.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2,
  parameter int          PRE_MIN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        link_up,
  output logic        reg_wr,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data
);

  typedef enum logic [2:0] {
    S_PRE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_IGNORE
  } state_t;

  localparam logic [5:0] PRE_MIN_C = 6'(PRE_MIN);

  state_t      state;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic        is_read;
  logic        op_hi;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic [15:0] reg0;
  logic [15:0] regs [4:15];

  logic mdc_s1, mdc_s2, mdc_s3;
  logic mdio_s1, mdio_s2;
  logic mdc_edge, bit_in;
  logic [4:0]  regad_next;
  logic [15:0] wr_word;
  logic [15:0] rd_word;

  assign mdc_edge   = mdc_s2 & ~mdc_s3;
  assign bit_in     = mdio_s2;
  assign regad_next = {regad[3:0], bit_in};
  assign wr_word    = {shreg[14:0], bit_in};

  // Read word is computed from the REGAD value being completed this edge
  always_comb begin
    rd_word = 16'h0000;
    case (regad_next)
      5'd0: rd_word = {1'b0, reg0[14:0]};
      5'd1: begin
        rd_word    = 16'h7949;
        rd_word[2] = link_up;
      end
      5'd2: rd_word = PHY_ID1;
      5'd3: rd_word = PHY_ID2;
      default: begin
        if (!regad_next[4] && regad_next[3:2] != 2'b00)
          rd_word = regs[regad_next[3:0]];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1      <= 1'b0;
      mdc_s2      <= 1'b0;
      mdc_s3      <= 1'b0;
      mdio_s1     <= 1'b1;
      mdio_s2     <= 1'b1;
      state       <= S_PRE;
      pre_cnt     <= 6'd0;
      bit_cnt     <= 5'd0;
      is_read     <= 1'b0;
      op_hi       <= 1'b0;
      phyad       <= 5'd0;
      regad       <= 5'd0;
      shreg       <= 16'h0000;
      reg0        <= 16'h1140;
      for (int i = 4; i <= 15; i++) regs[i] <= 16'h0000;
      mdio_o      <= 1'b1;
      mdio_t      <= 1'b1;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 5'd0;
      reg_wr_data <= 16'h0000;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
      reg_wr  <= 1'b0;
      if (mdc_edge) begin
        case (state)
          S_PRE: begin
            if (bit_in) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt >= PRE_MIN_C) begin
              state   <= S_ST2;
              pre_cnt <= 6'd0;
            end else begin
              pre_cnt <= 6'd0;
            end
          end
          S_ST2: begin
            bit_cnt <= 5'd0;
            state   <= bit_in ? S_OP : S_PRE;
          end
          S_OP: begin
            if (bit_cnt == 5'd0) begin
              op_hi   <= bit_in;
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= 5'd0;
              if (op_hi != bit_in) begin
                is_read <= op_hi;
                state   <= S_PHYAD;
              end else begin
                state <= S_PRE;
              end
            end
          end
          S_PHYAD: begin
            phyad <= {phyad[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              state   <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            regad <= regad_next;
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              if (phyad != PHY_ADDR) begin
                state <= S_IGNORE;
              end else begin
                state <= S_TA;
                if (is_read) shreg <= rd_word;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
              if (is_read) begin
                mdio_t <= 1'b0;
                mdio_o <= 1'b0;
              end
            end else begin
              bit_cnt <= 5'd0;
              state   <= S_DATA;
              if (is_read) begin
                mdio_o <= shreg[15];
                shreg  <= {shreg[14:0], 1'b0};
              end
            end
          end
          S_DATA: begin
            if (is_read) begin
              if (bit_cnt == 5'd15) begin
                mdio_t <= 1'b1;
                mdio_o <= 1'b1;
              end else begin
                mdio_o <= shreg[15];
                shreg  <= {shreg[14:0], 1'b0};
              end
            end else begin
              shreg <= wr_word;
              // Writes above reg 15 still pulse reg_wr but update nothing
              if (bit_cnt == 5'd15) begin
                reg_wr      <= 1'b1;
                reg_wr_addr <= regad;
                reg_wr_data <= wr_word;
                if (regad == 5'd0)
                  reg0 <= wr_word[15] ? 16'h1140 : wr_word;
                else if (!regad[4] && regad[3:2] != 2'b00)
                  regs[regad[3:0]] <= wr_word;
              end
            end
            if (bit_cnt == 5'd15) begin
              bit_cnt <= 5'd0;
              state   <= S_PRE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_IGNORE: begin
            if (bit_cnt == 5'd17) begin
              bit_cnt <= 5'd0;
              state   <= S_PRE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: state <= S_PRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: a bit-banged MDIO master with scoreboard queues
// for expected register writes and read data.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_drv;
  logic        link_up;
  logic        mdio_o;
  logic        mdio_t;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        mdio_line;

  int total  = 0;
  int passed = 0;
  int wr_seen = 0;

  logic [20:0] exp_wr_q [$];
  logic [15:0] exp_rd_q [$];

  // Open-drain style line: master's value when the PHY releases, else the PHY's
  assign mdio_line = mdio_t ? mdio_drv : mdio_o;

  always #5 clk = ~clk;

  mdio_phy_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mdc         (mdc),
    .mdio_i      (mdio_line),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .link_up     (link_up),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data)
  );

  // Write scoreboard: each reg_wr pulse is matched against the oldest expected write
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      logic [20:0] exp_w;
      wr_seen++;
      total++;
      if (exp_wr_q.size() == 0) begin
        $display("[TB] FAIL unexpected_reg_wr: got addr=%0d data=%h, required no write",
                 reg_wr_addr, reg_wr_data);
      end else begin
        exp_w = exp_wr_q.pop_front();
        if ({reg_wr_addr, reg_wr_data} !== exp_w)
          $display("[TB] FAIL reg_wr: got addr=%0d data=%h, required addr=%0d data=%h",
                   reg_wr_addr, reg_wr_data, exp_w[20:16], exp_w[15:0]);
        else
          passed++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic mdc_bit(input logic b, output logic so, output logic st);
    mdio_drv = b;
    mdc = 1'b0;
    repeat (4) @(negedge clk);
    so = mdio_line;
    st = mdio_t;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] reg_a, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int t_low, output int t_first);
    logic [31:0] fr;
    logic so, st, b;
    fr = {2'b01, op, phy, reg_a,
          (op == 2'b10) ? 2'b11 : 2'b10,
          (op == 2'b10) ? 16'hFFFF : wdata};
    t_low = 0;
    t_first = -1;
    rdata = 16'h0000;
    for (int i = 0; i < pre_len; i++) begin
      mdc_bit(1'b1, so, st);
      if (st !== 1'b1) t_low++;
    end
    for (int i = 0; i < 33; i++) begin
      b = (i < 32) ? fr[31-i] : 1'b0;
      mdc_bit(b, so, st);
      if (st !== 1'b1) begin
        t_low++;
        if (t_first < 0) t_first = i;
      end
      if (i >= 16 && i < 32) rdata[31-i] = so;
    end
  endtask

  task automatic test_reset;
    logic [15:0] rd, exp_r;
    int tl, tf;
    rst = 1'b1;
    mdc = 1'b0;
    mdio_drv = 1'b1;
    link_up = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (mdio_t !== 1'b1) $display("[TB] FAIL rst_mdio_t: got %b, required 1", mdio_t); else passed++;
    total++; if (mdio_o !== 1'b1) $display("[TB] FAIL rst_mdio_o: got %b, required 1", mdio_o); else passed++;
    total++; if (reg_wr !== 1'b0) $display("[TB] FAIL rst_reg_wr: got %b, required 0", reg_wr); else passed++;
    total++; if (reg_wr_addr !== 5'd0) $display("[TB] FAIL rst_wr_addr: got %0d, required 0", reg_wr_addr); else passed++;
    total++; if (reg_wr_data !== 16'h0) $display("[TB] FAIL rst_wr_data: got %h, required 0000", reg_wr_data); else passed++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_rd_q.push_back(16'h1140);
    run_frame(32, 2'b10, 5'd0, 5'd0, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg0_reset: got %h, required %h", rd, exp_r); else passed++;
    exp_rd_q.push_back(16'h0000);
    run_frame(32, 2'b10, 5'd0, 5'd4, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg4_reset: got %h, required %h", rd, exp_r); else passed++;
  endtask

  task automatic test_write_read_reg4;
    logic [15:0] rd, exp_r;
    int tl, tf, w0;
    w0 = wr_seen;
    exp_wr_q.push_back({5'd4, 16'hA5C3});
    run_frame(32, 2'b01, 5'd0, 5'd4, 16'hA5C3, rd, tl, tf);
    total++; if (tl != 0) $display("[TB] FAIL write_no_drive: got %0d low bits, required 0", tl); else passed++;
    total++; if (wr_seen != w0 + 1) $display("[TB] FAIL write_pulse_count: got %0d, required %0d", wr_seen - w0, 1); else passed++;
    exp_rd_q.push_back(16'hA5C3);
    run_frame(32, 2'b10, 5'd0, 5'd4, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL read_reg4: got %h, required %h", rd, exp_r); else passed++;
    total++; if (tl != 17) $display("[TB] FAIL drive_len: got %0d, required 17", tl); else passed++;
    total++; if (tf != 15) $display("[TB] FAIL drive_start: got bit %0d, required 15", tf); else passed++;
  endtask

  task automatic test_id_and_status;
    logic [15:0] rd, exp_r;
    int tl, tf;
    exp_rd_q.push_back(16'h0141);
    run_frame(32, 2'b10, 5'd0, 5'd2, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL phy_id1: got %h, required %h", rd, exp_r); else passed++;
    exp_rd_q.push_back(16'h0CC2);
    run_frame(32, 2'b10, 5'd0, 5'd3, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL phy_id2: got %h, required %h", rd, exp_r); else passed++;
    link_up = 1'b1;
    exp_rd_q.push_back(16'h794D);
    run_frame(32, 2'b10, 5'd0, 5'd1, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL status_link_up: got %h, required %h", rd, exp_r); else passed++;
    link_up = 1'b0;
    exp_rd_q.push_back(16'h7949);
    run_frame(32, 2'b10, 5'd0, 5'd1, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL status_link_down: got %h, required %h", rd, exp_r); else passed++;
    link_up = 1'b1;
  endtask

  task automatic test_wrong_phyad;
    logic [15:0] rd, exp_r;
    int tl, tf, w0;
    w0 = wr_seen;
    run_frame(32, 2'b10, 5'd3, 5'd2, 16'h0, rd, tl, tf);
    total++; if (tl != 0) $display("[TB] FAIL foreign_read_drive: got %0d low bits, required 0", tl); else passed++;
    run_frame(32, 2'b01, 5'd3, 5'd4, 16'h1111, rd, tl, tf);
    total++; if (tl != 0) $display("[TB] FAIL foreign_write_drive: got %0d low bits, required 0", tl); else passed++;
    total++; if (wr_seen != w0) $display("[TB] FAIL foreign_write_pulse: got %0d pulses, required 0", wr_seen - w0); else passed++;
    exp_rd_q.push_back(16'hA5C3);
    run_frame(32, 2'b10, 5'd0, 5'd4, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL after_foreign_read: got %h, required %h", rd, exp_r); else passed++;
    total++; if (tl != 17) $display("[TB] FAIL after_foreign_drive_len: got %0d, required 17", tl); else passed++;
  endtask

  task automatic test_preamble_and_op;
    logic [15:0] rd, exp_r;
    int tl, tf, w0;
    w0 = wr_seen;
    run_frame(31, 2'b10, 5'd0, 5'd2, 16'h0, rd, tl, tf);
    total++; if (tl != 0) $display("[TB] FAIL short_preamble_drive: got %0d low bits, required 0", tl); else passed++;
    run_frame(32, 2'b11, 5'd0, 5'd4, 16'h0, rd, tl, tf);
    total++; if (tl != 0) $display("[TB] FAIL bad_op_drive: got %0d low bits, required 0", tl); else passed++;
    total++; if (wr_seen != w0) $display("[TB] FAIL bad_op_pulse: got %0d pulses, required 0", wr_seen - w0); else passed++;
    exp_rd_q.push_back(16'h0CC2);
    run_frame(32, 2'b10, 5'd0, 5'd3, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL after_bad_op_read: got %h, required %h", rd, exp_r); else passed++;
  endtask

  task automatic test_reg0_and_high;
    logic [15:0] rd, exp_r;
    int tl, tf, w0;
    exp_wr_q.push_back({5'd0, 16'h8000});
    run_frame(32, 2'b01, 5'd0, 5'd0, 16'h8000, rd, tl, tf);
    exp_rd_q.push_back(16'h1140);
    run_frame(32, 2'b10, 5'd0, 5'd0, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg0_self_reset: got %h, required %h", rd, exp_r); else passed++;
    exp_wr_q.push_back({5'd0, 16'h0100});
    run_frame(32, 2'b01, 5'd0, 5'd0, 16'h0100, rd, tl, tf);
    exp_rd_q.push_back(16'h0100);
    run_frame(32, 2'b10, 5'd0, 5'd0, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg0_write: got %h, required %h", rd, exp_r); else passed++;
    w0 = wr_seen;
    exp_wr_q.push_back({5'd20, 16'hFFFF});
    run_frame(32, 2'b01, 5'd0, 5'd20, 16'hFFFF, rd, tl, tf);
    total++; if (wr_seen != w0 + 1) $display("[TB] FAIL reg20_pulse: got %0d pulses, required 1", wr_seen - w0); else passed++;
    exp_rd_q.push_back(16'h0000);
    run_frame(32, 2'b10, 5'd0, 5'd20, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg20_read: got %h, required %h", rd, exp_r); else passed++;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] fr;
    logic [7:0]  part;
    logic [15:0] rd, exp_r;
    logic so, st;
    int tl, tf;
    fr = {2'b01, 2'b10, 5'd0, 5'd4, 2'b11, 16'hFFFF};
    part = 8'h00;
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, so, st);
    for (int i = 0; i < 24; i++) begin
      mdc_bit(fr[31-i], so, st);
      if (i >= 16) part[23-i] = so;
    end
    total++; if (part !== 8'hA5) $display("[TB] FAIL partial_read: got %h, required a5", part); else passed++;
    mdio_drv = 1'b1;
    mdc = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mdio_t !== 1'b0) $display("[TB] FAIL pre_reset_drive: got %b, required 0", mdio_t); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (mdio_t !== 1'b1) $display("[TB] FAIL reset_release_t: got %b, required 1", mdio_t); else passed++;
    total++; if (mdio_o !== 1'b1) $display("[TB] FAIL reset_release_o: got %b, required 1", mdio_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_rd_q.push_back(16'h0000);
    run_frame(32, 2'b10, 5'd0, 5'd4, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg4_after_reset: got %h, required %h", rd, exp_r); else passed++;
    total++; if (tl != 17) $display("[TB] FAIL after_reset_drive_len: got %0d, required 17", tl); else passed++;
    exp_wr_q.push_back({5'd7, 16'h3C5A});
    run_frame(32, 2'b01, 5'd0, 5'd7, 16'h3C5A, rd, tl, tf);
    exp_rd_q.push_back(16'h3C5A);
    run_frame(32, 2'b10, 5'd0, 5'd7, 16'h0, rd, tl, tf);
    exp_r = exp_rd_q.pop_front();
    total++; if (rd !== exp_r) $display("[TB] FAIL reg7_after_reset: got %h, required %h", rd, exp_r); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read_reg4();
    test_id_and_status();
    test_wrong_phyad();
    test_preamble_and_op();
    test_reg0_and_high();
    test_reset_mid_read();
    repeat (8) @(negedge clk);
    total++;
    if (exp_wr_q.size() != 0)
      $display("[TB] FAIL pending_writes: got %0d unseen writes, required 0", exp_wr_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
